// File: rtl/mic_volume_meter.sv
// rtl/mic_volume_meter.sv - windowed mic peak meter driving a 16-step volume bar
// Optional level decay across windows is enabled by defining MIC_VOLUME_METER_DECAY_EN.
module mic_volume_meter #(
  parameter int SAMPLE_W = 12,
  parameter int MIDSCALE = 2048,
  parameter int WINDOW   = 4000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] mic_in,
  output logic [3:0]          level,
  output logic [15:0]         bar_mask,
  output logic [SAMPLE_W-2:0] peak,
  output logic                level_valid
);

  localparam int A_W   = SAMPLE_W - 1;
  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam logic [SAMPLE_W-1:0] MID   = SAMPLE_W'(MIDSCALE);
  localparam logic [SAMPLE_W-1:0] A_MAX = SAMPLE_W'((1 << A_W) - 1);
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(WINDOW - 1);

  logic [CNT_W-1:0]    count;
  logic [A_W-1:0]      run_max;
  logic [SAMPLE_W-1:0] diff;
  logic [A_W-1:0]      amp;
  logic [A_W-1:0]      candidate;
  logic [3:0]          new_level;
  logic [3:0]          next_level;
  logic [15:0]         next_mask;
  logic                window_end;

  // The full-scale negative swing (mic_in=0) is one code larger than the positive one, so clamp it.
  always_comb begin
    diff       = (mic_in >= MID) ? (mic_in - MID) : (MID - mic_in);
    amp        = (diff > A_MAX) ? A_MAX[A_W-1:0] : diff[A_W-1:0];
    candidate  = (amp > run_max) ? amp : run_max;
    new_level  = candidate[A_W-1 -: 4];
    window_end = sample_valid && (count == LAST);
  end

  always_comb begin
`ifdef MIC_VOLUME_METER_DECAY_EN
    next_level = (new_level >= level) ? new_level : level - 4'd1;
`else
    next_level = new_level;
`endif
    next_mask = '0;
    for (int i = 0; i < 16; i++) begin
      next_mask[i] = (4'(i) <= next_level);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level       <= '0;
      bar_mask    <= 16'h0001;
      peak        <= '0;
      level_valid <= 1'b0;
      count       <= '0;
      run_max     <= '0;
    end else begin
      level_valid <= 1'b0;
      if (window_end) begin
        peak        <= candidate;
        level       <= next_level;
        bar_mask    <= next_mask;
        level_valid <= 1'b1;
        run_max     <= '0;
        count       <= '0;
      end else if (sample_valid) begin
        run_max <= candidate;
        count   <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mic_volume_meter.sv
// tb/tb_mic_volume_meter.sv - scoreboard bench for mic_volume_meter with WINDOW=4
module tb_mic_volume_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] mic_in = '0;
  logic [3:0]  level;
  logic [15:0] bar_mask;
  logic [10:0] peak;
  logic        level_valid;

  typedef struct packed {
    logic [3:0]  lvl;
    logic [15:0] mask;
    logic [10:0] pk;
  } exp_t;

  exp_t sb[$];
  int   pulse_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  int   pulses = 0;
  int   m_count = 0;
  int   m_max   = 0;
  int   m_level = 0;

  mic_volume_meter #(.SAMPLE_W(12), .MIDSCALE(2048), .WINDOW(4)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .mic_in(mic_in),
    .level(level), .bar_mask(bar_mask), .peak(peak), .level_valid(level_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  function automatic int amp_of(input int s);
    int a;
    a = s - 2048;
    if (a < 0) a = -a;
    if (a > 2047) a = 2047;
    return a;
  endfunction

  function automatic logic [15:0] therm(input int l);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i <= l; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic send(input int s);
    int   a;
    int   cand;
    int   nl;
    exp_t e;
    sample_valid = 1'b1;
    mic_in = s[11:0];
    a = amp_of(s);
    cand = (a > m_max) ? a : m_max;
    if (m_count == 3) begin
      nl = cand / 128;
`ifdef MIC_VOLUME_METER_DECAY_EN
      m_level = (nl >= m_level) ? nl : m_level - 1;
`else
      m_level = nl;
`endif
      e.lvl  = 4'(m_level);
      e.mask = therm(m_level);
      e.pk   = 11'(cand);
      sb.push_back(e);
      m_max = 0;
      m_count = 0;
    end else begin
      m_max = cand;
      m_count++;
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && level_valid) begin
      pulses++;
      pulse_cyc.push_back(cycle);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse at cycle %0d: level_valid=1, required 0", cycle);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({level, bar_mask, peak} !== e) begin
          errors++;
          $display("FAIL window_result: level=%0d mask=%h peak=%0d, required level=%0d mask=%h peak=%0d",
                   level, bar_mask, peak, e.lvl, e.mask, e.pk);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int p0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({level, bar_mask, peak, level_valid} !== {4'd0, 16'h0001, 11'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: level=%0d mask=%h peak=%0d lv=%b, required 0 0001 0 0",
               level, bar_mask, peak, level_valid);
    end
    p0 = pulses;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (pulses != p0 || level_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_pulse: pulses=%0d lv=%b, required %0d 0", pulses, level_valid, p0);
    end
  endtask

  task automatic test_basic();
    send(2048); send(2048); send(3072); send(2048);
    checks++;
    if ({level, bar_mask, peak, level_valid} !== {4'd8, 16'h01FF, 11'd1024, 1'b1}) begin
      errors++;
      $display("FAIL basic_window: level=%0d mask=%h peak=%0d lv=%b, required 8 01ff 1024 1",
               level, bar_mask, peak, level_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (level_valid !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: level_valid=%b, required 0", level_valid);
    end
    drain();
  endtask

  task automatic test_neg_swing();
    send(2048); send(2048); send(2048); send(0);
    checks++;
    if ({level, bar_mask, peak} !== {4'd15, 16'hFFFF, 11'd2047}) begin
      errors++;
      $display("FAIL neg_swing: level=%0d mask=%h peak=%0d, required 15 ffff 2047", level, bar_mask, peak);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    send(4095); send(4095);
    rst = 1'b1;
    m_count = 0; m_max = 0; m_level = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({level, peak, bar_mask} !== {4'd0, 11'd0, 16'h0001}) begin
      errors++;
      $display("FAIL reset_mid_state: level=%0d peak=%0d mask=%h, required 0 0 0001", level, peak, bar_mask);
    end
    send(2048); send(2048); send(2048); send(2048);
    checks++;
    if ({level, peak} !== {4'd0, 11'd0}) begin
      errors++;
      $display("FAIL reset_discard: level=%0d peak=%0d, required 0 0", level, peak);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = pulse_cyc.size();
    for (int i = 0; i < 8; i++) send(2176);
    drain();
    checks++;
    if (pulse_cyc.size() - c0 != 2) begin
      errors++;
      $display("FAIL b2b_pulse_count: %0d, required 2", pulse_cyc.size() - c0);
    end else begin
      checks++;
      if (pulse_cyc[c0+1] - pulse_cyc[c0] != 4) begin
        errors++;
        $display("FAIL b2b_spacing: %0d cycles, required 4", pulse_cyc[c0+1] - pulse_cyc[c0]);
      end
    end
    checks++;
    if ({level, bar_mask} !== {4'd1, 16'h0003}) begin
      errors++;
      $display("FAIL b2b_level: level=%0d mask=%h, required 1 0003", level, bar_mask);
    end
  endtask

  task automatic test_decay();
    int exp_l;
    send(2048); send(2048); send(2048); send(0);
    exp_l = 15;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) send(2048);
`ifdef MIC_VOLUME_METER_DECAY_EN
      exp_l = exp_l - 1;
`else
      exp_l = 0;
`endif
      checks++;
      if (level !== 4'(exp_l)) begin
        errors++;
        $display("FAIL decay_step%0d: level=%0d, required %0d", w, level, exp_l);
      end
    end
    send(4095); send(2048); send(2048); send(2048);
    checks++;
    if (level !== 4'd15) begin
      errors++;
      $display("FAIL decay_attack: level=%0d, required 15", level);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_basic();
    test_neg_swing();
    test_reset_mid();
    test_back_to_back();
    test_decay();
    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mic_volume_meter.md
Name: mic_volume_meter

Overview:
- Upstream feeder for the game screen's 16-step speaker-volume bar.
- Takes the 12-bit unsigned microphone sample stream at sample-strobe rate.
- Tracks the peak amplitude about midscale over a fixed window of samples.
- Once per window, quantises the peak to a 4-bit level and a 16-bit thermometer row mask; the renderer uses the mask to select lit rows r0..r15.

Parameters:
- SAMPLE_W, 12: microphone sample width in bits.
- MIDSCALE, 2048: silence code subtracted from each sample.
- WINDOW, 4000: samples per measurement window; legal range 1 to 65535.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe; mic_in is valid in that cycle.
- mic_in  input  SAMPLE_W  unsigned microphone sample.
- level  output  4  quantised volume, 0 to 15.
- bar_mask  output  16  thermometer code; bit i = 1 when i <= level; bit i lights row ri.
- peak  output  SAMPLE_W-1  latched peak amplitude of the last completed window.
- level_valid  output  1  one-cycle pulse when level, bar_mask and peak update.

Behaviour:
- Reset (async, active-high): level=0, bar_mask=16'h0001, peak=0, level_valid=0, sample counter=0, running max=0. Reset mid-window discards the partial window; counting restarts at the first sample_valid after reset deasserts.
- Amplitude: a = mic_in - MIDSCALE when mic_in >= MIDSCALE, else MIDSCALE - mic_in.
  - Saturate a to 2^(SAMPLE_W-1)-1 = 2047, so mic_in=0 gives 2047.
  - Width is SAMPLE_W-1 bits.
- Quantisation: q = a[SAMPLE_W-2 : SAMPLE_W-5], i.e. a>>7 for 12 bits, range 0 to 15.
- Cycles with sample_valid=0 change no state except clearing level_valid.
- Accumulate state, sample_valid=1 and counter < WINDOW-1:
  - running max = max(running max, a).
  - counter increments.
- Window-end state, sample_valid=1 and counter == WINDOW-1:
  - candidate = max(running max, a); the final sample is included.
  - Next edge: peak <= candidate, level <= q(candidate), bar_mask <= thermometer(level), level_valid <= 1.
  - Same edge: running max <= 0, counter <= 0.
- Latency: outputs change on the clock edge that samples the window's final strobe; level_valid is high for exactly the following cycle.
- sample_valid held high continuously: every cycle counts as one sample; no samples are dropped.
- WINDOW=1: every strobe is a window end; level follows each sample.
- Counter width: $clog2(WINDOW+1) bits. The counter wraps only through the window-end path and never exceeds WINDOW-1.
- level, bar_mask and peak hold their values between window ends.

Optional Feature:
- Macro: MIC_VOLUME_METER_DECAY_EN.
- Defined (decay at window end, with new = q(candidate)):
  - new >= level: level <= new (instant attack).
  - new < level: level <= level-1 (falls by one step per window).
  - peak always loads candidate.
  - bar_mask always tracks the registered level.
- Undefined: level <= new unconditionally (no decay).

Test Plan (bench uses WINDOW=4 unless stated):
- Reset release with no strobes: level=0, bar_mask=16'h0001, peak=0, level_valid stays 0 for 100 cycles.
- Strobe mic_in=2048,2048,3072,2048: one cycle after 4th strobe, peak=1024, level=8, bar_mask=16'h01FF, level_valid pulses for exactly 1 cycle.
- Strobe mic_in=0 on final sample of a window, others 2048: peak=2047, level=15, bar_mask=16'hFFFF; asymmetric negative swing is captured.
- Assert rst after 2 strobes of mic_in=4095, then 4 strobes of 2048: level=0, peak=0; pre-reset samples are discarded.
- sample_valid held high 8 consecutive cycles, mic_in=2176 (a=128): two level_valid pulses 4 cycles apart, level=1, bar_mask=16'h0003.
- With MIC_VOLUME_METER_DECAY_EN, one window at level 15 followed by silent windows: level goes 15,14,13,... one step per level_valid; a loud window restores 15 immediately. Without the macro, level drops to 0 after the first silent window.
